// File: rtl/counter_up_down.sv
// ---------------------------------------------------------------------------
// counter_up_down
//   Parameterised up/down counter with parallel load and a registered
//   wrap (or saturation) indicator. Loading has priority over counting.
//
//   Parameters:
//     WIDTH     counter width in bits (2..32)
//
//   Ports:
//     clk       clock, all state changes on its rising edge
//     rstn      asynchronous active-low reset
//     load_en   load count from 'load' at the next rising edge
//     load      parallel load value
//     down      direction: 0 counts up, 1 counts down
//     count     current counter value (registered)
//     rollover  one-cycle flag marking a wrap / blocked saturating step
//
//   Build option:
//     COUNTER_UD_SATURATE_EN  when defined, counting holds at the limits
//                             instead of wrapping; rollover then flags each
//                             edge whose step was blocked.
// ---------------------------------------------------------------------------
module counter_up_down #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  // One extra bit so the carry/borrow out of the MSB is visible.
  localparam int unsigned EXT_W = WIDTH + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             rollover_q, rollover_d;
  logic [WIDTH:0]   inc_c;
  logic [WIDTH:0]   dec_c;

  // Next-state: load, else step with carry/borrow driving rollover.
  always_comb begin
    inc_c      = {1'b0, count_q} + EXT_W'(1);
    dec_c      = {1'b0, count_q} - EXT_W'(1);
    count_d    = count_q;
    rollover_d = 1'b0;
    if (load_en) begin
      count_d = load;
    end else if (!down) begin
`ifdef COUNTER_UD_SATURATE_EN
      // Carry out means the step would leave the range: hold and flag it.
      if (inc_c[WIDTH]) begin
        rollover_d = 1'b1;
      end else begin
        count_d = inc_c[WIDTH-1:0];
      end
`else
      count_d    = inc_c[WIDTH-1:0];
      rollover_d = inc_c[WIDTH];
`endif
    end else begin
`ifdef COUNTER_UD_SATURATE_EN
      // Borrow out means we are at zero: hold and flag it.
      if (dec_c[WIDTH]) begin
        rollover_d = 1'b1;
      end else begin
        count_d = dec_c[WIDTH-1:0];
      end
`else
      count_d    = dec_c[WIDTH-1:0];
      rollover_d = dec_c[WIDTH];
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_counter_up_down.sv
// ---------------------------------------------------------------------------
// tb_counter_up_down
//   Self-checking bench for counter_up_down (WIDTH=4): reset behaviour,
//   a table of directed vectors, an asynchronous mid-count reset, and
//   randomly timed stimulus checked against a reference model.
// ---------------------------------------------------------------------------
module tb_counter_up_down;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NVEC  = 17;

  logic             clk;
  logic             rstn;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic [WIDTH-1:0] count;
  logic             rollover;

  int n_checks;
  int n_pass;

  typedef struct {
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [WIDTH-1:0] exp_count;
    logic             exp_roll;
  } vec_t;

  vec_t vecs [NVEC];

  counter_up_down #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load_en  (load_en),
    .load     (load),
    .down     (down),
    .count    (count),
    .rollover (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model of one rising edge.
  function automatic logic [WIDTH:0] model_step(input logic [WIDTH-1:0] c,
                                                input logic le,
                                                input logic [WIDTH-1:0] ld,
                                                input logic dn);
    logic [WIDTH-1:0] mx;
    mx = '1;
    if (le) return {1'b0, ld};
`ifdef COUNTER_UD_SATURATE_EN
    if (!dn) return (c == mx) ? {1'b1, mx} : {1'b0, c + 1'b1};
    return (c == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, c - 1'b1};
`else
    if (!dn) return (c == mx) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, c + 1'b1};
    return (c == '0) ? {1'b1, mx} : {1'b0, c - 1'b1};
`endif
  endfunction

  task automatic set_vec(input int i, input logic le, input logic [WIDTH-1:0] ld,
                         input logic dn, input logic [WIDTH-1:0] ec, input logic er);
    vecs[i].load_en   = le;
    vecs[i].load      = ld;
    vecs[i].down      = dn;
    vecs[i].exp_count = ec;
    vecs[i].exp_roll  = er;
  endtask

  logic [WIDTH-1:0] m_count;
  logic             m_roll;
  logic [WIDTH:0]   m_next;

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Directed vectors: {load_en, load, down} -> {count, rollover} after edge.
    set_vec(0,  1, 4'hE, 0, 4'hE, 0);
    set_vec(1,  0, 4'h0, 0, 4'hF, 0);
`ifdef COUNTER_UD_SATURATE_EN
    set_vec(2,  0, 4'h0, 0, 4'hF, 1);
    set_vec(3,  0, 4'h0, 0, 4'hF, 1);
`else
    set_vec(2,  0, 4'h0, 0, 4'h0, 1);
    set_vec(3,  0, 4'h0, 0, 4'h1, 0);
`endif
    set_vec(4,  1, 4'h1, 0, 4'h1, 0);
    set_vec(5,  0, 4'h0, 1, 4'h0, 0);
`ifdef COUNTER_UD_SATURATE_EN
    set_vec(6,  0, 4'h0, 1, 4'h0, 1);
    set_vec(7,  0, 4'h0, 1, 4'h0, 1);
`else
    set_vec(6,  0, 4'h0, 1, 4'hF, 1);
    set_vec(7,  0, 4'h0, 1, 4'hE, 0);
`endif
    set_vec(8,  1, 4'h5, 0, 4'h5, 0);
    set_vec(9,  1, 4'hA, 1, 4'hA, 0);   // load wins over down
    set_vec(10, 0, 4'h0, 1, 4'h9, 0);
    set_vec(11, 1, 4'hF, 0, 4'hF, 0);   // loading max: no rollover
    set_vec(12, 1, 4'h0, 1, 4'h0, 0);   // loading zero: no rollover
    set_vec(13, 0, 4'h0, 0, 4'h1, 0);
    set_vec(14, 0, 4'h0, 1, 4'h0, 0);
`ifdef COUNTER_UD_SATURATE_EN
    set_vec(15, 0, 4'h0, 1, 4'h0, 1);
`else
    set_vec(15, 0, 4'h0, 1, 4'hF, 1);
`endif
    set_vec(16, 1, 4'h3, 0, 4'h3, 0);   // load clears a pending rollover

    // Reset held for 5 edges with arbitrary inputs.
    rstn    = 1'b0;
    load_en = 1'b0;
    load    = '0;
    down    = 1'b0;
    #1;
    check("reset_t0_count", 32'(count), 32'h0);
    check("reset_t0_roll",  32'(rollover), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load_en = 1'($urandom);
      load    = WIDTH'($urandom);
      down    = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold_count", 32'(count), 32'h0);
      check("reset_hold_roll",  32'(rollover), 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      load_en = vecs[i].load_en;
      load    = vecs[i].load;
      down    = vecs[i].down;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_roll", i),  32'(rollover), 32'(vecs[i].exp_roll));
    end

    // Asynchronous reset mid-count: count 3 -> 6, then reset between edges.
    @(negedge clk);
    load_en = 1'b0;
    down    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_count", 32'(count), 32'h6);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'h0);
    check("async_reset_roll",  32'(rollover), 32'h0);
    @(posedge clk);
    #1;
    check("reset_edge_count", 32'(count), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_count", 32'(count), 32'h1);
    check("post_reset_roll",  32'(rollover), 32'h0);

    // Randomly timed stimulus vs reference model.
    m_count = 4'h1;
    m_roll  = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          #($urandom_range(1, 30));
          if (($time % 10) == 5) #1;   // keep changes off the rising edge
          load_en = 1'($urandom);
          load    = WIDTH'($urandom);
          down    = 1'($urandom);
        end
      end
      begin
        for (int e = 0; e < 18; e++) begin
          @(posedge clk);
          m_next  = model_step(m_count, load_en, load, down);
          m_count = m_next[WIDTH-1:0];
          m_roll  = m_next[WIDTH];
          #1;
          check($sformatf("rand%0d_count", e), 32'(count), 32'(m_count));
          check($sformatf("rand%0d_roll", e),  32'(rollover), 32'(m_roll));
        end
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_up_down.md
# counter_up_down

Parameterised synchronous up/down counter with parallel load and a registered wrap indicator. It is a general-purpose building block: timers, address generators and sequence counters instantiate it, and the surrounding logic drives direction and load controls each cycle. The counter advances on every clock edge unless reset is active or a load occurs.

## Interface
Parameters:
- WIDTH, default 4, counter width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rstn  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- load_en  input  1  when high at a rising edge, count takes the value on load.
- load  input  WIDTH  parallel load value.
- down  input  1  direction: 0 counts up, 1 counts down.
- count  output  WIDTH  current counter value, registered.
- rollover  output  1  one-cycle registered flag marking a wrap (or saturation event, see Configuration).

## Operation
- Reset: while rstn=0, count=0 and rollover=0, regardless of clk.
- Each rising edge with rstn=1, priority order:
  - load_en=1: count <= load; rollover <= 0. Load has priority over counting, and down is ignored.
  - load_en=0, down=0: count <= count+1, modulo 2^WIDTH.
  - load_en=0, down=1: count <= count-1, modulo 2^WIDTH.
- Wrap rules:
  - Up from 2^WIDTH-1 gives 0, with rollover <= 1.
  - Down from 0 gives 2^WIDTH-1, with rollover <= 1.
  - Every other counting edge sets rollover <= 0.
- rollover is high for exactly the one cycle in which count shows the wrapped value. A continuous wrap stream cannot occur for WIDTH ≥ 2.
- Arithmetic is unsigned and WIDTH bits wide. The carry and borrow out of the MSB are the sole source of rollover.
- Loading 2^WIDTH-1 or 0 does not assert rollover. A later count edge across the boundary does.
- Direction change takes effect on the next edge; there is no pipeline or hysteresis.
- No internal state exists beyond the count and rollover registers.

## Timing
- Load latency: 1 cycle. The load value appears on count after the edge that samples load_en=1.
- Count latency: 1 cycle per step. Outputs are pure register outputs with no combinational path from inputs.
- rollover is asserted in the same cycle as the wrapped count value and deasserts at the next edge.
- Reset assertion mid-operation clears count and rollover immediately, asynchronously.
- Reset deassertion: the first edge with rstn=1 performs a normal count or load. Release rstn synchronously to clk at system level.
- Inputs must meet setup and hold to clk. They may change at any point between edges; only the value at the rising edge matters.

## Configuration
- Macro COUNTER_UD_SATURATE_EN.
- Undefined (default): modulo wrap behaviour as described above.
- Defined:
  - Counting up at 2^WIDTH-1 holds 2^WIDTH-1.
  - Counting down at 0 holds 0.
  - rollover <= 1 on every edge where a step was blocked by saturation. This gives a one-cycle pulse per blocked edge, so it stays high while held at the limit.
  - Load behaviour is unchanged.

## Test plan
- Reset: hold rstn=0 for 5 edges with arbitrary inputs, then assert rstn=0 mid-count. Required response: count=0 and rollover=0 immediately, and throughout reset.
- Up wrap (WIDTH=4): load 0xE, then down=0 for 3 edges. Required response: count 0xF, 0x0, 0x1, with rollover high only while count=0x0.
- Down wrap: load 0x1, then down=1 for 3 edges. Required response: count 0x0, 0xF, 0xE, with rollover high only while count=0xF.
- Load priority: count=0x5, then load_en=1, load=0xA, down=1 for one edge. Required response: count=0xA, rollover=0; the next edge with load_en=0, down=1 gives 0x9.
- Randomised stimulus: 5 random (load, load_en, down) sets applied at random 1-30 time-unit offsets. Required response: count matches a reference model at every edge.
- With COUNTER_UD_SATURATE_EN: load 0xE, then count up 3 edges. Required response: count 0xF, 0xF, 0xF, with rollover 0, 1, 1.
